trap_control: RTL and testbench
===============================

Name: trap_control

Overview:
Writeback-stage sequencer that drives the CSR file's write port and trap/mret inputs, and consumes its interrupt-pending and vector outputs. For each instruction leaving the memory stage, it decides one of four outcomes: retire, execute a CSR read-modify-write, take an exception or interrupt, or perform mret. On a trap or mret it squashes the pipeline and runs a redirect handshake with fetch.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC loaded into redirect_pc by reset; not otherwise used.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
valid_in  in  1  memory stage presents an instruction
pc_in  in  32  PC of that instruction
csr_op  in  2  0 none, 1 RW, 2 RS, 3 RC
csr_src_zero  in  1  rs1 index / zimm is zero (RS/RC do not write)
csr_address  in  12  CSR address
csr_source  in  32  rs1 value or zero-extended zimm
csr_read_data  in  32  value read at decode
csr_readable  in  1  CSR exists
csr_writeable  in  1  CSR is writable
exc_illegal, exc_fetch_misaligned, exc_load_misaligned, exc_store_misaligned, is_ecall, is_ebreak, is_mret  in  1 each  decoded flags
eip, tip, sip  in  1 each  gated pending interrupts from the CSR file
trap_vector, mret_vector  in  32 each  from the CSR file
write_enable  out  1  CSR write strobe
write_address  out  12  CSR write address
write_data  out  32  CSR write value
retired, traped, mret  out  1 each  to the CSR file
ecp  out  32  exception PC
trap_cause  out  4  cause code
interupt  out  1  cause is an interrupt
flush  out  1  squash the decode, execute and memory stages
redirect_valid  out  1  fetch redirect request
redirect_pc  out  32  redirect target
redirect_ready  in  1  fetch accepts the redirect

Behaviour:
- FSM states: RUN and REDIRECT. Reset puts the FSM in REDIRECT with redirect_pc = RESET_VECTOR. All other outputs reset to 0.
- The strobes write_enable, retired, traped, mret, flush and the CSR data outputs are combinational from the inputs and the state. They are valid only in RUN with valid_in = 1. The CSR file samples them on the next posedge.
- Instruction accepted in RUN with valid_in = 1. Decision priority, highest first:
  1. Interrupt: eip → cause 11; else sip → cause 3; else tip → cause 7; interupt = 1.
  2. exc_fetch_misaligned → cause 0.
  3. Illegal → cause 2. Illegal means exc_illegal, or csr_op != 0 with !csr_readable, or a writing CSR op with !csr_writeable.
  4. is_ebreak → cause 3.
  5. is_ecall → cause 11.
  6. exc_load_misaligned → cause 4.
  7. exc_store_misaligned → cause 6.
  8. is_mret.
  9. CSR op.
  10. Plain retire.
- Writing CSR op: RW always writes. RS and RC write only when !csr_src_zero.
- Trap (cases 1-7): traped = 1, ecp = pc_in, trap_cause and interupt set per case, flush = 1, write_enable = 0, retired = 0. Latch redirect_pc ← trap_vector; next state REDIRECT.
- mret (case 8): mret = 1, retired = 1, flush = 1. Latch redirect_pc ← mret_vector; next state REDIRECT.
- CSR op (case 9): retired = 1; write_enable when the op writes; write_address = csr_address. write_data is csr_source for RW, csr_read_data | csr_source for RS, csr_read_data & ~csr_source for RC.
- REDIRECT state:
  - redirect_valid = 1 and flush = 1; valid_in is ignored (squashed, nothing retires, no CSR writes).
  - redirect_pc is held stable until redirect_ready.
  - Go to RUN on the cycle redirect_valid && redirect_ready.
  - Interrupts arriving in REDIRECT are deferred until the next accepted instruction.
- Simultaneous trap and CSR write on the same instruction: the trap wins and no CSR write occurs.
- Reset asserted mid-REDIRECT: redirect_pc is forced to RESET_VECTOR immediately (asynchronous).

Decomposition:
- Shared package holds cause-code constants (CAUSE_FETCH_MISALIGNED = 0, ILLEGAL = 2, BREAKPOINT = 3, LOAD_MISALIGNED = 4, STORE_MISALIGNED = 6, ECALL_M = 11; interrupts MSI = 3, MTI = 7, MEI = 11), the csr_op encoding, and the FSM state enum.
- One natural sub-module: trap_priority, a combinational encoder producing take_trap, cause and is_interrupt.

Test Plan:
- Out of reset: redirect_valid = 1, redirect_pc = 0; hold redirect_ready = 0 for 3 cycles → pc stays 0, flush stays 1; ready = 1 → RUN on the next cycle.
- CSRRS on 0x340 with read 0x0F0, source 0x00F → write_enable = 1, write_data = 0x0FF, retired = 1. Same op with csr_src_zero = 1 → write_enable = 0, retired = 1.
- ecall at pc 0x80 with trap_vector 0x100 → traped = 1, ecp = 0x80, cause = 11, interupt = 0. Then redirect_pc = 0x100 and redirect_valid until ready.
- CSRRW to non-writable 0xC00 → illegal trap, cause 2, write_enable = 0.
- eip and tip both set with a valid CSRRW pending → interrupt cause 11, interupt = 1, no CSR write. After redirect, tip alone → cause 7.
- mret with mret_vector 0x2A4 → mret = 1, retired = 1, flush = 1, redirect_pc = 0x2A4. Instructions presented during REDIRECT produce no retired.

Source files
------------

// File: rtl/trap_control_pkg.sv
// Shared definitions for the writeback trap sequencer: cause codes,
// CSR operation encoding and the FSM state type.
package trap_control_pkg;

  localparam logic [3:0] CAUSE_FETCH_MISALIGNED = 4'd0;
  localparam logic [3:0] CAUSE_ILLEGAL          = 4'd2;
  localparam logic [3:0] CAUSE_BREAKPOINT       = 4'd3;
  localparam logic [3:0] CAUSE_LOAD_MISALIGNED  = 4'd4;
  localparam logic [3:0] CAUSE_STORE_MISALIGNED = 4'd6;
  localparam logic [3:0] CAUSE_ECALL_M          = 4'd11;

  localparam logic [3:0] CAUSE_MSI = 4'd3;
  localparam logic [3:0] CAUSE_MTI = 4'd7;
  localparam logic [3:0] CAUSE_MEI = 4'd11;

  typedef enum logic [1:0] {
    CSR_NONE = 2'd0,
    CSR_RW   = 2'd1,
    CSR_RS   = 2'd2,
    CSR_RC   = 2'd3
  } csr_op_e;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_REDIRECT = 1'b1
  } state_e;

  // RS/RC with a zero source are pure reads and must not touch the CSR.
  function automatic logic csr_op_writes(input logic [1:0] op, input logic src_zero);
    return (op == CSR_RW) || ((op != CSR_NONE) && !src_zero);
  endfunction

endpackage

// File: rtl/trap_control_priority.sv
// Combinational trap priority encoder: interrupts first, then synchronous
// exceptions in architectural order.
module trap_priority
  import trap_control_pkg::*;
(
  input  logic       eip,
  input  logic       tip,
  input  logic       sip,
  input  logic       exc_fetch_misaligned,
  input  logic       illegal,
  input  logic       is_ebreak,
  input  logic       is_ecall,
  input  logic       exc_load_misaligned,
  input  logic       exc_store_misaligned,
  output logic       take_trap,
  output logic [3:0] cause,
  output logic       is_interrupt
);

  always_comb begin
    take_trap    = 1'b1;
    is_interrupt = 1'b0;
    cause        = 4'd0;
    if (eip) begin
      cause        = CAUSE_MEI;
      is_interrupt = 1'b1;
    end else if (sip) begin
      cause        = CAUSE_MSI;
      is_interrupt = 1'b1;
    end else if (tip) begin
      cause        = CAUSE_MTI;
      is_interrupt = 1'b1;
    end else if (exc_fetch_misaligned) begin
      cause = CAUSE_FETCH_MISALIGNED;
    end else if (illegal) begin
      cause = CAUSE_ILLEGAL;
    end else if (is_ebreak) begin
      cause = CAUSE_BREAKPOINT;
    end else if (is_ecall) begin
      cause = CAUSE_ECALL_M;
    end else if (exc_load_misaligned) begin
      cause = CAUSE_LOAD_MISALIGNED;
    end else if (exc_store_misaligned) begin
      cause = CAUSE_STORE_MISALIGNED;
    end else begin
      take_trap = 1'b0;
    end
  end

endmodule

// File: rtl/trap_control.sv
// Writeback-stage sequencer: retires, performs CSR read-modify-writes, takes
// traps and mret, and runs the fetch redirect handshake afterwards.
module trap_control
  import trap_control_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [31:0] pc_in,
  input  logic [1:0]  csr_op,
  input  logic        csr_src_zero,
  input  logic [11:0] csr_address,
  input  logic [31:0] csr_source,
  input  logic [31:0] csr_read_data,
  input  logic        csr_readable,
  input  logic        csr_writeable,
  input  logic        exc_illegal,
  input  logic        exc_fetch_misaligned,
  input  logic        exc_load_misaligned,
  input  logic        exc_store_misaligned,
  input  logic        is_ecall,
  input  logic        is_ebreak,
  input  logic        is_mret,
  input  logic        eip,
  input  logic        tip,
  input  logic        sip,
  input  logic [31:0] trap_vector,
  input  logic [31:0] mret_vector,
  output logic        write_enable,
  output logic [11:0] write_address,
  output logic [31:0] write_data,
  output logic        retired,
  output logic        traped,
  output logic        mret,
  output logic [31:0] ecp,
  output logic [3:0]  trap_cause,
  output logic        interupt,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready
);

  state_e     state, state_next;
  logic       accept;
  logic       csr_writes;
  logic       illegal;
  logic       take_trap;
  logic [3:0] cause;
  logic       is_interrupt;

  assign accept     = (state == ST_RUN) && valid_in;
  assign csr_writes = csr_op_writes(csr_op, csr_src_zero);
  assign illegal    = exc_illegal
                    || ((csr_op != CSR_NONE) && !csr_readable)
                    || (csr_writes && !csr_writeable);

  trap_priority u_priority (
    .eip                  (eip),
    .tip                  (tip),
    .sip                  (sip),
    .exc_fetch_misaligned (exc_fetch_misaligned),
    .illegal              (illegal),
    .is_ebreak            (is_ebreak),
    .is_ecall             (is_ecall),
    .exc_load_misaligned  (exc_load_misaligned),
    .exc_store_misaligned (exc_store_misaligned),
    .take_trap            (take_trap),
    .cause                (cause),
    .is_interrupt         (is_interrupt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_REDIRECT;
    end else begin
      state <= state_next;
    end
  end

  // The redirect target is captured at the decision point and frozen
  // through the whole handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      redirect_pc <= RESET_VECTOR;
    end else if (accept && take_trap) begin
      redirect_pc <= trap_vector;
    end else if (accept && is_mret) begin
      redirect_pc <= mret_vector;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_RUN: begin
        if (accept && (take_trap || is_mret)) begin
          state_next = ST_REDIRECT;
        end
      end
      ST_REDIRECT: begin
        if (redirect_ready) begin
          state_next = ST_RUN;
        end
      end
      default: state_next = ST_REDIRECT;
    endcase
  end

  always_comb begin
    write_enable   = 1'b0;
    write_address  = 12'd0;
    write_data     = 32'd0;
    retired        = 1'b0;
    traped         = 1'b0;
    mret           = 1'b0;
    ecp            = 32'd0;
    trap_cause     = 4'd0;
    interupt       = 1'b0;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    if (state == ST_REDIRECT) begin
      redirect_valid = 1'b1;
      flush          = 1'b1;
    end else if (valid_in) begin
      if (take_trap) begin
        traped     = 1'b1;
        ecp        = pc_in;
        trap_cause = cause;
        interupt   = is_interrupt;
        flush      = 1'b1;
      end else if (is_mret) begin
        mret    = 1'b1;
        retired = 1'b1;
        flush   = 1'b1;
      end else begin
        retired = 1'b1;
        if (csr_op != CSR_NONE) begin
          write_enable  = csr_writes;
          write_address = csr_address;
          case (csr_op)
            CSR_RW:  write_data = csr_source;
            CSR_RS:  write_data = csr_read_data | csr_source;
            CSR_RC:  write_data = csr_read_data & ~csr_source;
            default: write_data = 32'd0;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_trap_control.sv
// Scoreboard bench for trap_control: a driver pushes the expected per-cycle
// response from a reference model, a monitor pops and compares it.
module tb_trap_control;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic [31:0] pc_in;
  logic [1:0]  csr_op;
  logic        csr_src_zero;
  logic [11:0] csr_address;
  logic [31:0] csr_source, csr_read_data;
  logic        csr_readable, csr_writeable;
  logic        exc_illegal, exc_fetch_misaligned, exc_load_misaligned, exc_store_misaligned;
  logic        is_ecall, is_ebreak, is_mret;
  logic        eip, tip, sip;
  logic [31:0] trap_vector, mret_vector;
  logic        write_enable;
  logic [11:0] write_address;
  logic [31:0] write_data;
  logic        retired, traped, mret;
  logic [31:0] ecp;
  logic [3:0]  trap_cause;
  logic        interupt, flush, redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;

  always #5 clk = ~clk;

  trap_control dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .pc_in(pc_in),
    .csr_op(csr_op), .csr_src_zero(csr_src_zero), .csr_address(csr_address),
    .csr_source(csr_source), .csr_read_data(csr_read_data),
    .csr_readable(csr_readable), .csr_writeable(csr_writeable),
    .exc_illegal(exc_illegal), .exc_fetch_misaligned(exc_fetch_misaligned),
    .exc_load_misaligned(exc_load_misaligned), .exc_store_misaligned(exc_store_misaligned),
    .is_ecall(is_ecall), .is_ebreak(is_ebreak), .is_mret(is_mret),
    .eip(eip), .tip(tip), .sip(sip),
    .trap_vector(trap_vector), .mret_vector(mret_vector),
    .write_enable(write_enable), .write_address(write_address), .write_data(write_data),
    .retired(retired), .traped(traped), .mret(mret), .ecp(ecp),
    .trap_cause(trap_cause), .interupt(interupt), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready)
  );

  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic [1:0]  op;
    logic        sz;
    logic [11:0] addr;
    logic [31:0] src;
    logic [31:0] rd;
    logic        rdable, wable;
    logic        ill, fmis, lmis, smis, ecall, ebreak, mret_i;
    logic        eip, tip, sip;
    logic [31:0] tvec, mvec;
    logic        rdy;
  } stim_t;

  typedef struct packed {
    logic        we;
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic        retired, traped, mret;
    logic [31:0] ecp;
    logic [3:0]  cause;
    logic        intr, flush, rvalid;
    logic [31:0] rpc;
  } resp_t;

  resp_t q[$];
  int    errors = 0;
  int    checks = 0;

  // Reference model state: are we waiting on fetch, and where to.
  bit          m_redirecting;
  logic [31:0] m_rpc;

  function automatic stim_t idle();
    stim_t s = '0;
    s.rdable = 1'b1;
    s.wable  = 1'b1;
    return s;
  endfunction

  function automatic resp_t predict(input stim_t s);
    resp_t e = '0;
    bit writes, illegal;
    e.rpc = m_rpc;
    if (m_redirecting) begin
      e.rvalid = 1'b1;
      e.flush  = 1'b1;
      return e;
    end
    if (!s.v) return e;
    writes  = (s.op == 2'd1) || (s.op != 2'd0 && !s.sz);
    illegal = s.ill || (s.op != 2'd0 && !s.rdable) || (writes && !s.wable);
    if (s.eip || s.sip || s.tip) begin
      e.traped = 1'b1;
      e.intr   = 1'b1;
      e.cause  = s.eip ? 4'd11 : (s.sip ? 4'd3 : 4'd7);
    end else if (s.fmis)   begin e.traped = 1'b1; e.cause = 4'd0;  end
    else if (illegal)      begin e.traped = 1'b1; e.cause = 4'd2;  end
    else if (s.ebreak)     begin e.traped = 1'b1; e.cause = 4'd3;  end
    else if (s.ecall)      begin e.traped = 1'b1; e.cause = 4'd11; end
    else if (s.lmis)       begin e.traped = 1'b1; e.cause = 4'd4;  end
    else if (s.smis)       begin e.traped = 1'b1; e.cause = 4'd6;  end
    if (e.traped) begin
      e.ecp   = s.pc;
      e.flush = 1'b1;
    end else if (s.mret_i) begin
      e.mret    = 1'b1;
      e.retired = 1'b1;
      e.flush   = 1'b1;
    end else begin
      e.retired = 1'b1;
      if (writes) begin
        e.we    = 1'b1;
        e.waddr = s.addr;
        case (s.op)
          2'd1:    e.wdata = s.src;
          2'd2:    e.wdata = s.rd | s.src;
          default: e.wdata = s.rd & ~s.src;
        endcase
      end
    end
    return e;
  endfunction

  task automatic advance_model(input stim_t s, input resp_t e);
    if (m_redirecting) begin
      if (s.rdy) m_redirecting = 1'b0;
    end else if (e.traped) begin
      m_rpc = s.tvec;
      m_redirecting = 1'b1;
    end else if (e.mret) begin
      m_rpc = s.mvec;
      m_redirecting = 1'b1;
    end
  endtask

  task automatic apply(input stim_t s);
    resp_t e;
    @(posedge clk);
    #1;
    valid_in = s.v; pc_in = s.pc; csr_op = s.op; csr_src_zero = s.sz;
    csr_address = s.addr; csr_source = s.src; csr_read_data = s.rd;
    csr_readable = s.rdable; csr_writeable = s.wable;
    exc_illegal = s.ill; exc_fetch_misaligned = s.fmis;
    exc_load_misaligned = s.lmis; exc_store_misaligned = s.smis;
    is_ecall = s.ecall; is_ebreak = s.ebreak; is_mret = s.mret_i;
    eip = s.eip; tip = s.tip; sip = s.sip;
    trap_vector = s.tvec; mret_vector = s.mvec; redirect_ready = s.rdy;
    e = predict(s);
    q.push_back(e);
    advance_model(s, e);
  endtask

  // Fields that are don't-care when their strobe is low are masked out.
  function automatic resp_t mask(input resp_t r, input resp_t ref_r);
    resp_t m = r;
    if (!ref_r.we) begin m.waddr = '0; m.wdata = '0; end
    if (!ref_r.traped) begin m.ecp = '0; m.cause = '0; m.intr = 1'b0; end
    return m;
  endfunction

  always @(negedge clk) begin
    resp_t exp_r, act;
    if (q.size() > 0) begin
      exp_r = q.pop_front();
      act.we = write_enable; act.waddr = write_address; act.wdata = write_data;
      act.retired = retired; act.traped = traped; act.mret = mret;
      act.ecp = ecp; act.cause = trap_cause; act.intr = interupt;
      act.flush = flush; act.rvalid = redirect_valid; act.rpc = redirect_pc;
      act = mask(act, exp_r);
      checks++;
      if (act !== mask(exp_r, exp_r)) begin
        errors++;
        $display("FAIL cycle_resp t=%0t got we=%b wa=%h wd=%h ret=%b trp=%b mret=%b ecp=%h cause=%0d int=%b fl=%b rv=%b rpc=%h | want we=%b wa=%h wd=%h ret=%b trp=%b mret=%b ecp=%h cause=%0d int=%b fl=%b rv=%b rpc=%h",
          $time, act.we, act.waddr, act.wdata, act.retired, act.traped, act.mret, act.ecp, act.cause, act.intr, act.flush, act.rvalid, act.rpc,
          exp_r.we, exp_r.waddr, exp_r.wdata, exp_r.retired, exp_r.traped, exp_r.mret, exp_r.ecp, exp_r.cause, exp_r.intr, exp_r.flush, exp_r.rvalid, exp_r.rpc);
      end
    end
  end

  task automatic check1(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  initial begin
    stim_t s;
    int budget;
    reset = 1'b1;
    s = idle();
    valid_in = 0; pc_in = 0; csr_op = 0; csr_src_zero = 0; csr_address = 0;
    csr_source = 0; csr_read_data = 0; csr_readable = 1; csr_writeable = 1;
    exc_illegal = 0; exc_fetch_misaligned = 0; exc_load_misaligned = 0;
    exc_store_misaligned = 0; is_ecall = 0; is_ebreak = 0; is_mret = 0;
    eip = 0; tip = 0; sip = 0; trap_vector = 0; mret_vector = 0; redirect_ready = 0;
    m_redirecting = 1'b1;
    m_rpc = 32'h0;
    #1;
    check1("reset_redirect_valid", {31'd0, redirect_valid}, 32'd1);
    check1("reset_redirect_pc", redirect_pc, 32'h0);
    check1("reset_retired", {31'd0, retired}, 32'd0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;

    // Hold off fetch for three cycles, then accept.
    repeat (3) apply(idle());
    s = idle(); s.rdy = 1'b1; apply(s);

    // CSRRS 0x340, then the same with a zero source.
    s = idle(); s.v = 1; s.op = 2'd2; s.addr = 12'h340; s.rd = 32'h0F0; s.src = 32'h00F;
    apply(s);
    s.sz = 1'b1; apply(s);

    // ecall, fetch stalls once, an instruction shows up during redirect.
    s = idle(); s.v = 1; s.pc = 32'h80; s.ecall = 1; s.tvec = 32'h100; apply(s);
    s = idle(); s.v = 1; s.pc = 32'h84; apply(s);
    s = idle(); s.rdy = 1; apply(s);

    // CSRRW to a read-only CSR traps as illegal.
    s = idle(); s.v = 1; s.op = 2'd1; s.addr = 12'hC00; s.wable = 0; s.src = 32'h5;
    s.pc = 32'h90; s.tvec = 32'h200; apply(s);
    s = idle(); s.rdy = 1; apply(s);

    // eip + tip beat a pending CSRRW; then tip alone.
    s = idle(); s.v = 1; s.op = 2'd1; s.addr = 12'h340; s.src = 32'hAA;
    s.eip = 1; s.tip = 1; s.pc = 32'hA0; s.tvec = 32'h300; apply(s);
    s = idle(); s.v = 1; s.tip = 1; s.rdy = 1; apply(s);
    s = idle(); s.v = 1; s.tip = 1; s.pc = 32'hB0; s.tvec = 32'h304; apply(s);
    s = idle(); s.rdy = 1; apply(s);

    // mret, with instructions squashed while fetch stalls.
    s = idle(); s.v = 1; s.mret_i = 1; s.pc = 32'hC0; s.mvec = 32'h2A4; apply(s);
    s = idle(); s.v = 1; s.pc = 32'hC4; apply(s);
    apply(s);
    s.rdy = 1; apply(s);

    for (int i = 0; i < 500; i++) begin
      s = idle();
      s.v      = ($urandom % 4) != 0;
      s.pc     = $urandom & 32'hFFFF_FFFC;
      s.op     = 2'($urandom);
      s.sz     = ($urandom % 4) == 0;
      s.addr   = 12'($urandom);
      s.src    = $urandom;
      s.rd     = $urandom;
      s.rdable = ($urandom % 8) != 0;
      s.wable  = ($urandom % 8) != 0;
      s.ill    = ($urandom % 12) == 0;
      s.fmis   = ($urandom % 12) == 0;
      s.lmis   = ($urandom % 12) == 0;
      s.smis   = ($urandom % 12) == 0;
      s.ecall  = ($urandom % 12) == 0;
      s.ebreak = ($urandom % 12) == 0;
      s.mret_i = ($urandom % 10) == 0;
      s.eip    = ($urandom % 16) == 0;
      s.tip    = ($urandom % 16) == 0;
      s.sip    = ($urandom % 16) == 0;
      s.tvec   = $urandom;
      s.mvec   = $urandom;
      s.rdy    = ($urandom % 2) == 0;
      apply(s);
    end

    // Force a trap, then reset asynchronously while redirecting.
    s = idle(); s.v = 1; s.ecall = 1; s.pc = 32'h40; s.tvec = 32'hDEAD_0000; apply(s);
    s = idle(); apply(s);
    budget = 0;
    while (q.size() > 0 && budget < 20) begin @(negedge clk); budget++; end
    check1("drain_before_reset", q.size(), 32'd0);
    check1("pre_reset_pc", redirect_pc, 32'hDEAD_0000);
    #2 reset = 1'b1;
    #1;
    check1("async_reset_pc", redirect_pc, 32'h0);
    check1("async_reset_rvalid", {31'd0, redirect_valid}, 32'd1);
    @(posedge clk);
    #2 reset = 1'b0;
    m_redirecting = 1'b1;
    m_rpc = 32'h0;
    s = idle(); s.rdy = 1; apply(s);
    s = idle(); s.v = 1; apply(s);

    budget = 0;
    while (q.size() > 0 && budget < 20) begin @(negedge clk); budget++; end
    check1("final_drain", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
